dest_scoreboard_pipe: RTL
=========================

// Module: dest_scoreboard_pipe
// PURPOSE
//  Successor to the combinational ALU destination decoder. Decodes the
//  destination register and write-enable of each 16-bit instruction. Tracks
//  in-flight writes in a DEPTH-stage shift scoreboard and stalls the issuing
//  instruction on a RAW hazard. Emits the writeback {rd, we} DEPTH cycles
//  after issue. Sits between fetch/decode and the register-file write port.
// PARAMETERS
//  DEPTH  3  stages between issue and writeback; legal range 1..8
//  CNT_W  4  width of pend_count; must hold the value DEPTH
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  instr_valid  in   1      instr holds a candidate instruction
//  instr        in   16     instruction word
//  instr_ready  out  1      instr is accepted this cycle (comb.)
//  flush        in   1      kill all in-flight entries
//  wb_valid     out  1      registered; stage DEPTH-1 holds a live entry
//  wb_rd        out  3      registered; destination register at writeback
//  wb_we        out  1      registered; destination is written at writeback
//  hazard       out  1      comb.; source of instr matches a pending write
//  pend_count   out  CNT_W  registered; count of valid entries with we=1
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
//  Decode (op = instr[15:11]):
//   - 11011, 111xx, 11001: rd=instr[4:2], we=1
//   - 010xx, 101xx, 10001(LD): rd=instr[7:5], we=1
//   - 10011 (STU): rd=instr[10:8], we=1
//   - 11000 (LBI), 10010 (SLBI): rd=instr[10:8], we=1
//   - 00110 (JAL), 00111 (JALR): rd=3'd7, we=1
//   - all other ops, including 10000 (ST): rd=0, we=0
//  Sources:
//   - rs=instr[10:8] is used by 11011, 111xx, 11001, 010xx, 101xx, 100xx
//     except LBI/SLBI/ST/STU noted below, 011xx branches, 00101 (JR) and
//     00111 (JALR). SLBI, ST and STU also use rs.
//   - rt=instr[7:5] is used by 11011, 111xx, ST and STU.
//   - 01110 (RET) uses R7.
//  Scoreboard:
//   - Entries s[0..DEPTH-1], each {v, rd, we}. s[0] is the youngest.
//   - The scoreboard shifts every cycle; there is no downstream backpressure.
//   - s[0] loads the decoded entry when instr_valid & instr_ready.
//     Otherwise s[0] loads a bubble (v=0).
//  Hazard and issue:
//   - hazard = instr_valid & any used source equals s[k].rd with
//     s[k].v & s[k].we, for k in 0..DEPTH-1.
//   - An instruction never hazards against its own destination.
//   - instr_ready = ~rst & ~flush & ~hazard.
//  Latency: an instruction accepted in cycle t gives wb_valid=1 in cycle
//   t+DEPTH.
//  Writeback: wb_valid, wb_rd and wb_we mirror s[DEPTH-1].
//  Flush:
//   - All entries clear to v=0 on the next edge, and wb_valid=0 next cycle.
//   - flush has priority over issue: a simultaneous instr is not accepted.
//  Retiring entry: an entry in s[DEPTH-1] still raises a hazard in the cycle
//   it writes back (no WB->issue bypass).
//  pend_count: number of entries with v & we after the edge; never exceeds
//   DEPTH.
//  Reset values: all entries v=0, rd=0, we=0; wb_valid=0, wb_rd=0, wb_we=0,
//   pend_count=0.
//  Reset mid-stream: all in-flight writes are discarded; no writeback for them.
// CONFIGURATION
//  DEST_FWD_EN defined: hazard compares only s[0..DEPTH-2]. The register
//   file bypasses writes in the writeback cycle, so a dependent instruction
//   issues one cycle earlier. When DEPTH=1, hazard is constant 0.
//  DEST_FWD_EN undefined: hazard compares all DEPTH stages, as described
//   above.
// TESTING (DEPTH=3)
//  1. Issue 0xD94C (ADD R3) at cycle t
//     -> wb_valid=1, wb_rd=3, wb_we=1 at t+3; pend_count=1 for t+1..t+3.
//  2. Issue 0xD94C, then 0xDB70 (reads R3) held valid
//     -> instr_ready=0 for 3 cycles, 0xDB70 accepted at t+4.
//     With DEST_FWD_EN: 2 cycles, accepted at t+3.
//  3. Issue 0x3000 (JAL), 0xC205 (LBI R2), 0x8000 (ST), 0x0800 (NOP)
//     back-to-back
//     -> wb sequence {7,1}, {2,1}, {0,0}, {0,0}; no stall.
//  4. Issue 0x41A0 (ADDI R5), assert flush at t+1 with instr_valid=1
//     -> instr_ready=0 at t+1; no wb_valid at t+3; pend_count=0 at t+2.
//  5. Issue 0x41A0, assert rst at t+2
//     -> from t+3 wb_valid=0, pend_count=0, and all outputs at reset values.
//  6. 0x7000 (RET) presented while JAL is pending in s[1] -> hazard=1;
//     an unrelated source (0x6500, BEQZ R5) -> hazard=0.

Source files
------------

// File: rtl/dest_scoreboard_pipe.sv
// dest_scoreboard_pipe: decodes the destination {rd, we} of each 16-bit
// instruction, tracks in-flight writes in a DEPTH-stage shift scoreboard,
// stalls the issuing instruction on a RAW hazard and presents the writeback
// DEPTH cycles after issue.
// Optional macro DEST_FWD_EN: the register file bypasses the writeback-cycle
// write, so the retiring stage s[DEPTH-1] is excluded from hazard checks.
module dest_scoreboard_pipe #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    input  logic             flush,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic             wb_we,
    output logic             hazard,
    output logic [CNT_W-1:0] pend_count
);

    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       we;
    } sb_entry_t;

`ifdef DEST_FWD_EN
    localparam int HZ_N = DEPTH - 1;
`else
    localparam int HZ_N = DEPTH;
`endif

    sb_entry_t [DEPTH-1:0] s_q, s_d;
    logic [CNT_W-1:0]      pend_count_q, pend_count_d;

    logic [4:0] op;
    logic [2:0] rs, rt;
    logic [2:0] dec_rd;
    logic       dec_we;
    logic       use_rs, use_rt, use_r7;
    logic       hit;
    logic       unused_lsb;

    assign op         = instr[15:11];
    assign rs         = instr[10:8];
    assign rt         = instr[7:5];
    assign unused_lsb = ^instr[1:0];

    // Destination decode: which register the instruction writes, if any.
    always_comb begin
        dec_rd = 3'd0;
        dec_we = 1'b0;
        casez (op)
            5'b11011, 5'b111??, 5'b11001: begin dec_rd = instr[4:2];  dec_we = 1'b1; end
            5'b010??, 5'b101??, 5'b10001: begin dec_rd = instr[7:5];  dec_we = 1'b1; end
            5'b10011, 5'b11000, 5'b10010: begin dec_rd = instr[10:8]; dec_we = 1'b1; end
            5'b0011?:                     begin dec_rd = 3'd7;        dec_we = 1'b1; end
            default:                      begin dec_rd = 3'd0;        dec_we = 1'b0; end
        endcase
    end

    // Source decode: which register operands the instruction reads.
    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        casez (op)
            5'b11011, 5'b111??, 5'b11001, 5'b010??, 5'b101??,
            5'b100??, 5'b011??, 5'b00101, 5'b00111: use_rs = 1'b1;
            default:                                use_rs = 1'b0;
        endcase
        casez (op)
            5'b11011, 5'b111??, 5'b10000, 5'b10011: use_rt = 1'b1;
            default:                                use_rt = 1'b0;
        endcase
        use_r7 = (op == 5'b01110);
    end

    // RAW check against every live pending write (retiring stage optional).
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < HZ_N; k++) begin
            if (s_q[k].v && s_q[k].we) begin
                if (use_rs && (rs == s_q[k].rd))   hit = 1'b1;
                if (use_rt && (rt == s_q[k].rd))   hit = 1'b1;
                if (use_r7 && (s_q[k].rd == 3'd7)) hit = 1'b1;
            end
        end
    end

    assign hazard      = instr_valid & hit;
    assign instr_ready = ~rst & ~flush & ~hazard;

    // Next scoreboard: shift every cycle, load s[0] on issue, clear on flush.
    always_comb begin
        s_d = '0;
        if (!flush) begin
            for (int k = 1; k < DEPTH; k++) s_d[k] = s_q[k-1];
            if (instr_valid && instr_ready) begin
                s_d[0].v  = 1'b1;
                s_d[0].rd = dec_rd;
                s_d[0].we = dec_we;
            end
        end
    end

    // Pending write count as seen after the next edge.
    always_comb begin
        pend_count_d = '0;
        for (int k = 0; k < DEPTH; k++)
            if (s_d[k].v && s_d[k].we) pend_count_d = pend_count_d + CNT_W'(1);
    end

    // Scoreboard and count registers; reset discards every in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q          <= '0;
            pend_count_q <= '0;
        end else begin
            s_q          <= s_d;
            pend_count_q <= pend_count_d;
        end
    end

    assign wb_valid   = s_q[DEPTH-1].v;
    assign wb_rd      = s_q[DEPTH-1].rd;
    assign wb_we      = s_q[DEPTH-1].we;
    assign pend_count = pend_count_q;

endmodule
